// File: rtl/mac_stream_feeder_if.sv
// Bundle of write-port, frame-control and stream signals between the feeder
// and its environment (upstream writer plus downstream multiply-add block).
interface mac_stream_feeder_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_a;
    logic [7:0]    wr_b;
    logic          start;
    logic [AW:0]   len;
    logic [15:0]   acc_result;
    logic [7:0]    stream_a;
    logic [7:0]    stream_b;
    logic          busy;
    logic          done;
    logic [15:0]   dot_out;
    logic          start_err;

    modport master (
        output wr_en, wr_addr, wr_a, wr_b, start, len, acc_result,
        input  stream_a, stream_b, busy, done, dot_out, start_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_a, wr_b, start, len, acc_result,
        output stream_a, stream_b, busy, done, dot_out, start_err
    );
endinterface

// File: rtl/mac_stream_feeder.sv
// Operand buffer that streams {a,b} pairs into an external multiply-add block
// and reports the frame's dot product as the accumulator delta.
module mac_stream_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic clk,
    input  logic reset_n,
    mac_stream_feeder_if.slave feed_if
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN1, DRAIN2} state_t;

    localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);

    state_t      state_q;
    logic [AW:0] idx_q;
    logic [AW:0] len_q;
    logic [15:0] base_q;
    logic [7:0]  streamA_q;
    logic [7:0]  streamB_q;
    logic        busy_q;
    logic        done_q;
    logic        startErr_q;
    logic [15:0] dotOut_q;

    logic [7:0]  bufA_q [DEPTH];
    logic [7:0]  bufB_q [DEPTH];

    logic lenLegal;
    logic startAccept;
    logic wrAllowed;

    assign lenLegal    = (feed_if.len != '0) && (feed_if.len <= MAX_LEN);
    assign startAccept = (state_q == IDLE) && feed_if.start && lenLegal;
    assign wrAllowed   = (state_q == IDLE) && feed_if.wr_en && !startAccept;

    // Buffer contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wrAllowed) begin
            bufA_q[feed_if.wr_addr] <= feed_if.wr_a;
            bufB_q[feed_if.wr_addr] <= feed_if.wr_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            base_q     <= '0;
            streamA_q  <= '0;
            streamB_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            startErr_q <= 1'b0;
            dotOut_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            startErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (feed_if.start && lenLegal) begin
                        base_q    <= feed_if.acc_result;
                        len_q     <= feed_if.len;
                        streamA_q <= bufA_q[0];
                        streamB_q <= bufB_q[0];
                        idx_q     <= (AW+1)'(1);
                        busy_q    <= 1'b1;
                        state_q   <= STREAM;
                    end else if (feed_if.start) begin
                        startErr_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (idx_q == len_q) begin
                        streamA_q <= '0;
                        streamB_q <= '0;
                        state_q   <= DRAIN1;
                    end else begin
                        streamA_q <= bufA_q[idx_q[AW-1:0]];
                        streamB_q <= bufB_q[idx_q[AW-1:0]];
                        idx_q     <= idx_q + (AW+1)'(1);
                    end
                end
                DRAIN1: begin
                    state_q <= DRAIN2;
                end
                DRAIN2: begin
                    // Accumulator has absorbed the last product by now.
                    dotOut_q <= feed_if.acc_result - base_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign feed_if.stream_a  = streamA_q;
    assign feed_if.stream_b  = streamB_q;
    assign feed_if.busy      = busy_q;
    assign feed_if.done      = done_q;
    assign feed_if.dot_out   = dotOut_q;
    assign feed_if.start_err = startErr_q;

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Directed bench for mac_stream_feeder with a behavioural downstream
// accumulator that sums stream_a*stream_b each cycle.
module tb_mac_stream_feeder;

    logic clk;
    logic reset_n;
    int   checkCount;
    int   failCount;

    logic [7:0] expA [16];
    logic [7:0] expB [16];

    logic signed [15:0] acc;
    logic signed [15:0] aExt;
    logic signed [15:0] bExt;

    mac_stream_feeder_if #(.AW(4)) ifc ();

    mac_stream_feeder #(.DEPTH(16), .AW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .feed_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream multiply-add block, sharing reset_n with the feeder.
    assign aExt = {{8{ifc.stream_a[7]}}, ifc.stream_a};
    assign bExt = {{8{ifc.stream_b[7]}}, ifc.stream_b};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc <= '0;
        else          acc <= acc + aExt * bExt;
    end
    assign ifc.acc_result = acc;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic writeEntry(input int addr, input logic [7:0] a, input logic [7:0] b);
        ifc.wr_en   = 1'b1;
        ifc.wr_addr = 4'(addr);
        ifc.wr_a    = a;
        ifc.wr_b    = b;
        @(posedge clk); #1;
        ifc.wr_en   = 1'b0;
        expA[addr]  = a;
        expB[addr]  = b;
    endtask

    task automatic applyStimulus(input int l);
        ifc.start = 1'b1;
        ifc.len   = 5'(l);
        @(posedge clk); #1;
        ifc.start = 1'b0;
        ifc.len   = '0;
    endtask

    // Called just after the accepting edge; returns in the done cycle.
    task automatic watchFrame(input string name, input int l, input logic [15:0] expDot);
        checkOutput({name, ".busy0"}, 32'(ifc.busy), 32'd1);
        checkOutput({name, ".a0"}, 32'(ifc.stream_a), 32'(expA[0]));
        checkOutput({name, ".b0"}, 32'(ifc.stream_b), 32'(expB[0]));
        for (int cyc = 1; cyc <= l + 2; cyc++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("%s.a%0d", name, cyc), 32'(ifc.stream_a),
                        (cyc < l) ? 32'(expA[cyc]) : 32'd0);
            checkOutput($sformatf("%s.b%0d", name, cyc), 32'(ifc.stream_b),
                        (cyc < l) ? 32'(expB[cyc]) : 32'd0);
            checkOutput($sformatf("%s.busy%0d", name, cyc), 32'(ifc.busy),
                        (cyc < l + 2) ? 32'd1 : 32'd0);
            checkOutput($sformatf("%s.done%0d", name, cyc), 32'(ifc.done),
                        (cyc == l + 2) ? 32'd1 : 32'd0);
        end
        checkOutput({name, ".dot"}, 32'(ifc.dot_out), 32'(expDot));
    endtask

    task automatic checkQuiet(input string name, input logic [15:0] expDot);
        checkOutput({name, ".a"}, 32'(ifc.stream_a), 32'd0);
        checkOutput({name, ".b"}, 32'(ifc.stream_b), 32'd0);
        checkOutput({name, ".busy"}, 32'(ifc.busy), 32'd0);
        checkOutput({name, ".done"}, 32'(ifc.done), 32'd0);
        checkOutput({name, ".dot"}, 32'(ifc.dot_out), 32'(expDot));
    endtask

    initial begin
        checkCount  = 0;
        failCount   = 0;
        reset_n     = 1'b1;
        ifc.wr_en   = 1'b0;
        ifc.wr_addr = '0;
        ifc.wr_a    = '0;
        ifc.wr_b    = '0;
        ifc.start   = 1'b0;
        ifc.len     = '0;
        for (int i = 0; i < 16; i++) begin
            expA[i] = '0;
            expB[i] = '0;
        end
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkQuiet("reset", 16'h0000);
        checkOutput("reset.err", 32'(ifc.start_err), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic frame and back-to-back restart");
        writeEntry(0, 8'd1, 8'd4);
        writeEntry(1, 8'd2, 8'd5);
        writeEntry(2, 8'd3, 8'd6);
        applyStimulus(3);
        watchFrame("basic", 3, 16'd32);
        applyStimulus(3);
        watchFrame("b2b", 3, 16'd32);
        @(posedge clk); #1;
        checkQuiet("hold", 16'd32);

        $display("[TB] negative operands with nonzero base");
        writeEntry(0, 8'hFF, 8'd4);
        writeEntry(1, 8'hFE, 8'd5);
        writeEntry(2, 8'hFD, 8'd6);
        applyStimulus(3);
        watchFrame("neg", 3, 16'hFFE0);

        $display("[TB] illegal lengths");
        @(posedge clk); #1;
        applyStimulus(0);
        checkOutput("len0.err", 32'(ifc.start_err), 32'd1);
        checkQuiet("len0", 16'hFFE0);
        @(posedge clk); #1;
        checkOutput("len0.errclr", 32'(ifc.start_err), 32'd0);
        applyStimulus(17);
        checkOutput("len17.err", 32'(ifc.start_err), 32'd1);
        checkQuiet("len17", 16'hFFE0);
        @(posedge clk); #1;
        checkOutput("len17.errclr", 32'(ifc.start_err), 32'd0);

        $display("[TB] write attempts during a frame");
        applyStimulus(3);
        ifc.wr_en   = 1'b1;
        ifc.wr_addr = 4'd0;
        ifc.wr_a    = 8'd9;
        ifc.wr_b    = 8'd9;
        watchFrame("wrbusy", 3, 16'hFFE0);
        ifc.wr_en   = 1'b0;
        @(posedge clk); #1;
        applyStimulus(3);
        watchFrame("rerun", 3, 16'hFFE0);

        $display("[TB] full-depth wrap");
        for (int i = 0; i < 16; i++) writeEntry(i, 8'h80, 8'h80);
        applyStimulus(16);
        watchFrame("wrap", 16, 16'h0000);

        $display("[TB] reset in the middle of a frame");
        for (int i = 0; i < 8; i++) writeEntry(i, 8'(i + 1), 8'(i + 4));
        applyStimulus(8);
        @(posedge clk); #1;
        checkOutput("mid.a1", 32'(ifc.stream_a), 32'd2);
        reset_n = 1'b0;
        #1;
        checkQuiet("abort", 16'h0000);
        checkOutput("abort.err", 32'(ifc.start_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkQuiet("abortHold", 16'h0000);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("noDone%0d", i), 32'(ifc.done), 32'd0);
        end
        applyStimulus(3);
        watchFrame("postReset", 3, 16'd32);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mac_stream_feeder.md
MAC_STREAM_FEEDER -- requirements
Module: mac_stream_feeder

Interface
REQ-001 Parameter DEPTH, default 16: operand buffer depth and maximum vector length.
REQ-002 Parameter AW, default 4: buffer address width, with DEPTH = 2^AW.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  buffer write strobe.
REQ-006 wr_addr  input  AW  buffer write address.
REQ-007 wr_a  input  8  signed operand A to store.
REQ-008 wr_b  input  8  signed operand B to store.
REQ-009 start  input  1  frame start request.
REQ-010 len  input  AW+1  frame length, legal range 1..DEPTH.
REQ-011 acc_result  input  16  signed running sum from the downstream stream multiply-add block.
REQ-012 stream_a  output  8  signed operand A toward the multiply-add block.
REQ-013 stream_b  output  8  signed operand B toward the multiply-add block.
REQ-014 busy  output  1  frame in progress.
REQ-015 done  output  1  one-cycle pulse; dot_out is valid.
REQ-016 dot_out  output  16  signed dot product of the last completed frame.
REQ-017 start_err  output  1  one-cycle pulse; start rejected because len is illegal.

Function
REQ-018 Buffer: DEPTH entries of {a,b}; a write occurs on a rising edge with wr_en=1 only when state=IDLE and no start is accepted on that edge; otherwise the write is dropped.
REQ-019 Reading the buffer shall not modify its contents; a frame shall stream entries 0..len-1 in ascending address order.
REQ-020 FSM states: IDLE, STREAM, DRAIN1, DRAIN2.
REQ-021 IDLE with start=1 and len in 1..DEPTH: accept at edge E0; capture base <= acc_result; drive stream_a/b <= entry 0; idx <= 1; go to STREAM; busy <= 1.
REQ-022 IDLE with start=1 and len=0 or len>DEPTH: stay in IDLE; start_err pulses for one cycle; no other output changes.
REQ-023 start outside IDLE shall be ignored, with no start_err pulse.
REQ-024 STREAM: each edge drives entry idx and increments idx; on the edge where idx==len, drive stream_a/b <= 0 and go to DRAIN1 (edge E_len).
REQ-025 DRAIN1 goes to DRAIN2 unconditionally; stream_a/b stay 0.
REQ-026 DRAIN2 at edge E_len+2: dot_out <= acc_result - base (modulo 2^16); done <= 1 for one cycle; busy <= 0; go to IDLE.
REQ-027 Latency: done is high during the cycle following E_len+2, i.e. len+2 edges after the accepting edge.
REQ-028 stream_a/b shall be 0 in every cycle that is not carrying a frame element, so the downstream accumulator holds steady between frames.
REQ-029 Arithmetic: subtraction is 16-bit two's complement; dot_out equals the true sum of a[i]*b[i] truncated to 16 bits; no saturation and no overflow flag.
REQ-030 A start in the cycle where done=1 (state IDLE) shall be accepted; base captures the just-final acc_result.
REQ-031 dot_out shall hold its value until the next done pulse.

Reset
REQ-032 reset_n=0, asynchronous, forces: state=IDLE, stream_a=0, stream_b=0, busy=0, done=0, start_err=0, dot_out=0, base=0, idx=0.
REQ-033 Buffer contents are not reset and are undefined after power-up until written.
REQ-034 Reset mid-frame aborts the frame immediately; no done pulse is issued for the aborted frame.
REQ-035 Operation resumes on the first rising edge after reset_n deasserts; the downstream block shares reset_n, so its accumulator is also zeroed.

Verification
REQ-036 Basic frame: write a=[1,2,3], b=[4,5,6]; start with len=3 -> stream shows (1,4),(2,5),(3,6),0; done pulses 5 edges after accept (len+2); dot_out=32.
REQ-037 Back-to-back frames with a nonzero base: frame 1 as in REQ-036; start in the done cycle with a=[-1,-2,-3], b=[4,5,6] -> dot_out=-32 (0xFFE0).
REQ-038 Wrap: len=16, all entries a=-128, b=-128 -> dot_out=0x0000 (262144 mod 65536); no saturation.
REQ-039 Illegal length: start with len=0, then with len=17 -> start_err pulses once for each; busy stays 0; stream outputs stay 0.
REQ-040 Write during busy: wr_en to addr 0 with a=9 mid-frame -> write dropped; a rerun of the same frame gives an identical dot_out.
REQ-041 Reset mid-frame: assert reset_n=0 at idx=2 of a len=8 frame -> all outputs 0 immediately; no done pulse; a subsequent len=3 frame gives the correct result.
